// File: rtl/rgmii_transmitter.sv
`timescale 1ns / 1ps
// ---------------------------------------------------------------------------
// rgmii_transmitter
//
// Transmit half of the RGMII MAC/PHY interface. Takes frame bytes (CRC already
// appended) from a valid/ready/last stream. It prepends preamble + SFD, holds
// off for the inter-packet gap after every frame, and drives the 4-bit DDR
// TXD / TX_CTL pins plus the forwarded TXC. It moves one byte per 125 MHz clock.
//
// Parameters
//   XILINX          1: ODDRE1 primitives drive the pins (synthesis only),
//                   0: behavioural DDR model
//   PREAMBLE_BYTES  number of 0x55 bytes before the SFD (1..15)
//   IPG_BYTES       idle byte-times after each frame or discard (1..255)
//
// Optional feature macro
//   RGMII_TX_ERROR_PROPAGATION_EN
//     defined   : an underrun puts one 0x00 byte on the wire with TX_EN=1,
//                 TX_ER=1, so the PHY signals a receive error to the far end
//     undefined : an underrun simply drops TX_EN and truncates the frame;
//                 the far end rejects it on CRC
//
// Ports
//   clock          in   125 MHz TX clock
//   reset_n        in   asynchronous, active-low reset
//   s_data[7:0]    in   frame byte
//   s_valid        in   s_data valid
//   s_last         in   s_data is the final byte of the frame
//   s_ready        out  byte accepted when s_valid && s_ready at posedge
//   rgmii_txd[3:0] out  DDR data: rise = byte[3:0], fall = byte[7:4]
//   rgmii_tx_ctl   out  DDR control: rise = TX_EN, fall = TX_EN ^ TX_ER
//   rgmii_txc      out  forwarded clock, in phase with clock
//   tx_busy        out  high whenever the FSM is not IDLE
//   underrun       out  one-cycle pulse after s_valid dropped mid-frame
//   frame_count    out  frames completed cleanly (wraps)
// ---------------------------------------------------------------------------
module rgmii_transmitter #(
    parameter int XILINX         = 0,
    parameter int PREAMBLE_BYTES = 7,
    parameter int IPG_BYTES      = 12
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [7:0]  s_data,
    input  logic        s_valid,
    input  logic        s_last,
    output logic        s_ready,
    output logic [3:0]  rgmii_txd,
    output logic        rgmii_tx_ctl,
    output logic        rgmii_txc,
    output logic        tx_busy,
    output logic        underrun,
    output logic [31:0] frame_count
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PREAMBLE,
        ST_SFD,
        ST_DATA,
        ST_UNDERRUN,
        ST_DISCARD,
        ST_IPG
    } state_t;

    localparam logic [7:0] PREAMBLE_LAST = 8'(PREAMBLE_BYTES - 1);
    localparam logic [7:0] IPG_LAST      = 8'(IPG_BYTES - 1);
    localparam logic [7:0] PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0] SFD_BYTE      = 8'hD5;

`ifdef RGMII_TX_ERROR_PROPAGATION_EN
    localparam logic ERR_TX_EN = 1'b1;
    localparam logic ERR_TX_ER = 1'b1;
`else
    localparam logic ERR_TX_EN = 1'b0;
    localparam logic ERR_TX_ER = 1'b0;
`endif

    state_t     state;
    logic [7:0] count;

    // Byte stage: the byte that the DDR stage puts on the pins at the next edge.
    logic [7:0] txd8;
    logic       tx_en;
    logic       tx_er;

    // Behavioural DDR registers: {ctl, nibble} for the rising and falling halves.
    logic [4:0] rise_q;
    logic [4:0] fall_q;

    // Main FSM. It also loads the byte stage, so every pin value is registered.
    // The first preamble byte is loaded on the edge that leaves IDLE. This
    // makes the idle run between frames exactly IPG_BYTES byte-times, even
    // though IDLE itself takes one cycle to notice s_valid.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_IDLE;
            count       <= 8'd0;
            s_ready     <= 1'b0;
            tx_busy     <= 1'b0;
            underrun    <= 1'b0;
            frame_count <= 32'd0;
            txd8        <= 8'd0;
            tx_en       <= 1'b0;
            tx_er       <= 1'b0;
        end else begin
            underrun <= 1'b0;
            txd8     <= 8'd0;
            tx_en    <= 1'b0;
            tx_er    <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (s_valid) begin
                        txd8    <= PREAMBLE_BYTE;
                        tx_en   <= 1'b1;
                        tx_busy <= 1'b1;
                        count   <= 8'd1;
                        if (PREAMBLE_BYTES == 1) begin
                            state <= ST_SFD;
                        end else begin
                            state <= ST_PREAMBLE;
                        end
                    end
                end

                ST_PREAMBLE: begin
                    txd8  <= PREAMBLE_BYTE;
                    tx_en <= 1'b1;
                    if (count == PREAMBLE_LAST) begin
                        state <= ST_SFD;
                    end else begin
                        count <= count + 8'd1;
                    end
                end

                // s_ready is raised here so that it is already high in the
                // first DATA cycle.
                ST_SFD: begin
                    txd8    <= SFD_BYTE;
                    tx_en   <= 1'b1;
                    s_ready <= 1'b1;
                    state   <= ST_DATA;
                end

                ST_DATA: begin
                    if (s_valid) begin
                        txd8  <= s_data;
                        tx_en <= 1'b1;
                        if (s_last) begin
                            s_ready     <= 1'b0;
                            count       <= 8'd0;
                            frame_count <= frame_count + 32'd1;
                            state       <= ST_IPG;
                        end
                    end else begin
                        // The error byte (or idle) goes into the byte stage on
                        // this edge. It then follows the last good byte on the
                        // wire with no gap.
                        txd8     <= 8'd0;
                        tx_en    <= ERR_TX_EN;
                        tx_er    <= ERR_TX_ER;
                        underrun <= 1'b1;
                        s_ready  <= 1'b0;
                        state    <= ST_UNDERRUN;
                    end
                end

                ST_UNDERRUN: begin
                    s_ready <= 1'b1;
                    state   <= ST_DISCARD;
                end

                ST_DISCARD: begin
                    if (s_valid && s_last) begin
                        s_ready <= 1'b0;
                        count   <= 8'd0;
                        state   <= ST_IPG;
                    end
                end

                ST_IPG: begin
                    if (count == IPG_LAST) begin
                        tx_busy <= 1'b0;
                        state   <= ST_IDLE;
                    end else begin
                        count <= count + 8'd1;
                    end
                end

                default: begin
                    s_ready <= 1'b0;
                    tx_busy <= 1'b0;
                    state   <= ST_IDLE;
                end
            endcase
        end
    end

    // Behavioural DDR stage. Both halves of a byte are captured on the same
    // rising edge (SAME_EDGE). The level of clock then chooses which half is
    // on the pins: rise data while clock is high, fall data while it is low.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rise_q <= 5'd0;
            fall_q <= 5'd0;
        end else begin
            rise_q <= {tx_en, txd8[3:0]};
            fall_q <= {tx_en ^ tx_er, txd8[7:4]};
        end
    end

    generate
        if (XILINX != 0) begin : g_oddr
`ifdef SYNTHESIS
            for (genvar i = 0; i < 4; i++) begin : g_txd
                ODDRE1 #(
                    .SRVAL(1'b0)
                ) u_oddr_txd (
                    .Q (rgmii_txd[i]),
                    .C (clock),
                    .D1(txd8[i]),
                    .D2(txd8[i+4]),
                    .SR(!reset_n)
                );
            end

            ODDRE1 #(
                .SRVAL(1'b0)
            ) u_oddr_ctl (
                .Q (rgmii_tx_ctl),
                .C (clock),
                .D1(tx_en),
                .D2(tx_en ^ tx_er),
                .SR(!reset_n)
            );

            // The reset is not applied to TXC, so the PHY keeps its clock
            // while the MAC is held in reset.
            ODDRE1 #(
                .SRVAL(1'b0)
            ) u_oddr_txc (
                .Q (rgmii_txc),
                .C (clock),
                .D1(1'b1),
                .D2(1'b0),
                .SR(1'b0)
            );
`else
            // The vendor primitive only exists in the vendor library. Outside
            // synthesis, the behavioural model stands in for it.
            assign rgmii_txd    = clock ? rise_q[3:0] : fall_q[3:0];
            assign rgmii_tx_ctl = clock ? rise_q[4]   : fall_q[4];
            assign rgmii_txc    = clock;
`endif
        end else begin : g_behav
            assign rgmii_txd    = clock ? rise_q[3:0] : fall_q[3:0];
            assign rgmii_tx_ctl = clock ? rise_q[4]   : fall_q[4];
            assign rgmii_txc    = clock;
        end
    endgenerate

endmodule

// File: tb/tb_rgmii_transmitter.sv
`timescale 1ns / 1ps
// ---------------------------------------------------------------------------
// tb_rgmii_transmitter
//
// Scoreboard bench for rgmii_transmitter. Each applied frame pushes its
// expected wire bytes (preamble, SFD, data, optional error byte) into a queue.
// A monitor rebuilds bytes from the DDR pins, pops the queue and compares.
// Idle byte-times must show all-zero pins. Where a test asks for it, the
// length of the idle run before a frame is checked too.
// ---------------------------------------------------------------------------
module tb_rgmii_transmitter;

    logic        clock;
    logic        reset_n;
    logic [7:0]  s_data;
    logic        s_valid;
    logic        s_last;
    logic        s_ready;
    logic [3:0]  rgmii_txd;
    logic        rgmii_tx_ctl;
    logic        rgmii_txc;
    logic        tx_busy;
    logic        underrun;
    logic [31:0] frame_count;

    typedef struct {
        logic [7:0] data;
        logic       ctl_fall;
        int         gap;
    } wire_t;

    wire_t exp_q[$];

    int n_checks      = 0;
    int n_errors      = 0;
    bit mon_en        = 1'b0;
    int idle_run      = 0;
    int underrun_seen = 0;

    rgmii_transmitter dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .s_data      (s_data),
        .s_valid     (s_valid),
        .s_last      (s_last),
        .s_ready     (s_ready),
        .rgmii_txd   (rgmii_txd),
        .rgmii_tx_ctl(rgmii_tx_ctl),
        .rgmii_txc   (rgmii_txc),
        .tx_busy     (tx_busy),
        .underrun    (underrun),
        .frame_count (frame_count)
    );

    initial begin
        clock = 1'b0;
        forever #4 clock = ~clock;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t",
                     name, actual, expected, $time);
        end
    endtask

    task automatic pushExpected(input logic [7:0] d, input logic cf, input int g);
        wire_t e;
        e.data     = d;
        e.ctl_fall = cf;
        e.gap      = g;
        exp_q.push_back(e);
    endtask

    // Drives one frame of len bytes (base, base+1, ...). Called right after a
    // negedge. If underrun_after >= 0, s_valid drops for one cycle before that
    // byte index. gap: required idle run before the first preamble byte (-1 = no
    // check). exp_wait: required posedges from presenting byte 0 to its
    // acceptance (-1 = no check).
    task automatic applyStimulus(input int len, input logic [7:0] base,
                                 input int underrun_after, input int gap,
                                 input int exp_wait);
        int n_wire;
        int waits;
        bit acc;
        bit accepted;

        pushExpected(8'h55, 1'b1, gap);
        for (int p = 1; p < 7; p++) pushExpected(8'h55, 1'b1, -1);
        pushExpected(8'hD5, 1'b1, -1);
        n_wire = (underrun_after >= 0) ? underrun_after : len;
        for (int i = 0; i < n_wire; i++) pushExpected(8'(int'(base) + i), 1'b1, -1);
`ifdef RGMII_TX_ERROR_PROPAGATION_EN
        if (underrun_after >= 0) pushExpected(8'h00, 1'b0, -1);
`endif

        for (int i = 0; i < len; i++) begin
            if (underrun_after >= 0 && i == underrun_after) begin
                s_valid = 1'b0;
                s_last  = 1'b0;
                @(negedge clock);
            end
            s_valid  = 1'b1;
            s_data   = 8'(int'(base) + i);
            s_last   = (i == len - 1);
            waits    = 0;
            accepted = 1'b0;
            while (!accepted && waits < 200) begin
                acc = s_ready;
                @(negedge clock);
                waits++;
                accepted = acc;
            end
            if (!accepted) begin
                checkOutput("handshake_timeout", 32'd1, 32'd0);
                s_valid = 1'b0;
                s_last  = 1'b0;
                return;
            end
            if (i == 0 && exp_wait >= 0)
                checkOutput("first_accept_cycles", waits, exp_wait);
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic waitIdle();
        int n = 0;
        while (tx_busy && n < 500) begin
            @(negedge clock);
            n++;
        end
        if (tx_busy) checkOutput("idle_timeout", 32'd1, 32'd0);
        repeat (4) @(negedge clock);
    endtask

    // Wire monitor: rebuilds a byte from the rise/fall halves and checks it
    // against the scoreboard.
    initial begin : monitor
        logic [3:0] r_d;
        logic [3:0] f_d;
        logic       r_c;
        logic       f_c;
        wire_t      e;
        forever begin
            @(posedge clock);
            #1;
            r_d = rgmii_txd;
            r_c = rgmii_tx_ctl;
            @(negedge clock);
            #1;
            f_d = rgmii_txd;
            f_c = rgmii_tx_ctl;
            if (mon_en) begin
                if (r_c) begin
                    if (exp_q.size() == 0) begin
                        checkOutput("wire_unexpected_byte", 32'd1, 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        checkOutput("wire_byte", 32'({f_d, r_d}), 32'(e.data));
                        checkOutput("wire_ctl_fall", 32'(f_c), 32'(e.ctl_fall));
                        if (e.gap >= 0) checkOutput("ipg_len", idle_run, e.gap);
                    end
                    idle_run = 0;
                end else begin
                    idle_run++;
                    checkOutput("idle_pins", 32'({f_d, f_c, r_d}), 32'd0);
                end
            end
        end
    end

    initial begin : underrun_counter
        forever begin
            @(posedge clock);
            #1;
            if (underrun === 1'b1) underrun_seen++;
        end
    end

    initial begin : watchdog
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : main
        int und_before;

        reset_n = 1'b1;
        s_valid = 1'b0;
        s_last  = 1'b0;
        s_data  = 8'h00;
        #1 reset_n = 1'b0;
        #1;
        checkOutput("reset_txd", 32'(rgmii_txd), 32'd0);
        checkOutput("reset_tx_ctl", 32'(rgmii_tx_ctl), 32'd0);
        checkOutput("reset_s_ready", 32'(s_ready), 32'd0);
        checkOutput("reset_tx_busy", 32'(tx_busy), 32'd0);
        checkOutput("reset_underrun", 32'(underrun), 32'd0);
        checkOutput("reset_frame_count", frame_count, 32'd0);
        @(negedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        idle_run = 0;
        mon_en   = 1'b1;

        $display("[TB] normal 64-byte frame");
        applyStimulus(64, 8'h00, -1, -1, 9);
        waitIdle();
        checkOutput("frame_count_normal", frame_count, 32'd1);
        checkOutput("queue_empty_normal", exp_q.size(), 0);
        checkOutput("underrun_none", underrun_seen, 0);

        $display("[TB] reset mid-preamble");
        mon_en  = 1'b0;
        s_valid = 1'b1;
        s_data  = 8'h77;
        s_last  = 1'b0;
        repeat (4) @(negedge clock);
        #2;
        checkOutput("pre_reset_tx_ctl", 32'(rgmii_tx_ctl), 32'd1);
        checkOutput("pre_reset_txd", 32'(rgmii_txd), 32'h5);
        reset_n = 1'b0;
        s_valid = 1'b0;
        #1;
        checkOutput("midreset_txd", 32'(rgmii_txd), 32'd0);
        checkOutput("midreset_tx_ctl", 32'(rgmii_tx_ctl), 32'd0);
        checkOutput("midreset_tx_busy", 32'(tx_busy), 32'd0);
        checkOutput("midreset_s_ready", 32'(s_ready), 32'd0);
        checkOutput("midreset_frame_count", frame_count, 32'd0);
        checkOutput("midreset_txc_low", 32'(rgmii_txc), 32'(clock));
        @(posedge clock);
        #1;
        checkOutput("midreset_txc_high", 32'(rgmii_txc), 32'd1);
        checkOutput("midreset_txd_held", 32'(rgmii_txd), 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        repeat (2) @(negedge clock);
        exp_q.delete();
        idle_run = 0;
        mon_en   = 1'b1;

        $display("[TB] back-to-back frames");
        applyStimulus(16, 8'h80, -1, -1, 9);
        applyStimulus(8, 8'hC0, -1, 12, 21);
        waitIdle();
        checkOutput("frame_count_b2b", frame_count, 32'd2);
        checkOutput("queue_empty_b2b", exp_q.size(), 0);

        $display("[TB] underrun then single-byte frame");
        und_before = underrun_seen;
        applyStimulus(20, 8'h20, 10, -1, 9);
        applyStimulus(1, 8'hA5, -1, -1, 21);
        waitIdle();
        checkOutput("underrun_pulses", underrun_seen - und_before, 1);
        checkOutput("frame_count_underrun", frame_count, 32'd3);
        checkOutput("queue_empty_underrun", exp_q.size(), 0);

        $display("[TB] frame_count wrap");
        force dut.frame_count = 32'hFFFF_FFFF;
        @(negedge clock);
        release dut.frame_count;
        @(negedge clock);
        applyStimulus(4, 8'h10, -1, -1, 9);
        waitIdle();
        checkOutput("frame_count_wrap", frame_count, 32'd0);
        checkOutput("queue_empty_final", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
